// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit register: load, toggle, JK update, and shift/rotate that moves one bit per clock.
// The completion handshake is Busy/Done. Clr is synchronous, and Reset_n clears everything asynchronously.
module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] K,
    input  logic [AMT_W-1:0] Amt,
    input  logic             Sin,
    input  logic             Clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             Sout,
    output logic             Busy,
    output logic             Done
);
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_TOG  = 3'b110;
    localparam logic [2:0] OP_JK   = 3'b111;

    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] rem_q, rem_d;

    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_q;
    logic             step_sout;
    logic [AMT_W-1:0] n_amt;

    assign n_amt = (Amt > AMT_MAX) ? AMT_MAX : Amt;

    // One-bit move. In IDLE it uses the live Op for the accept edge; after that it uses the latched op.
    always_comb begin
        step_op   = (state_q == SHIFT) ? op_q : Op;
        step_q    = q_q;
        step_sout = sout_q;
        case (step_op)
            OP_SHL: begin step_q = {q_q[WIDTH-2:0], Sin};      step_sout = q_q[WIDTH-1]; end
            OP_SHR: begin step_q = {Sin, q_q[WIDTH-1:1]};      step_sout = q_q[0];       end
            OP_ROL: begin step_q = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; step_sout = q_q[WIDTH-1]; end
            OP_ROR: begin step_q = {q_q[0], q_q[WIDTH-1:1]};   step_sout = q_q[0];       end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        op_d    = op_q;
        rem_d   = rem_q;
        if (Clr) begin
            state_d = IDLE;
            q_d     = '0;
            sout_d  = 1'b0;
            rem_d   = '0;
        end else if (state_q == IDLE) begin
            if (Start) begin
                op_d   = Op;
                done_d = 1'b1;
                case (Op)
                    OP_HOLD: ;
                    OP_LOAD: q_d = D;
                    OP_TOG:  q_d = q_q ^ D;
                    OP_JK:   q_d = (D & ~q_q) | (~K & q_q);
                    OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                        if (n_amt != '0) begin
                            q_d    = step_q;
                            sout_d = step_sout;
                            if (n_amt != AMT_ONE) begin
                                state_d = SHIFT;
                                rem_d   = n_amt - AMT_ONE;
                                done_d  = 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            q_d    = step_q;
            sout_d = step_sout;
            rem_d  = rem_q - AMT_ONE;
            if (rem_q == AMT_ONE) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

    assign Q    = q_q;
    assign Qbar = ~q_q;
    assign Sout = sout_q;
    assign Busy = (state_q == SHIFT);
    assign Done = done_q;
endmodule

// File: tb/tb_shift_reg_universal.sv
// Randomized, self-checking bench for shift_reg_universal (WIDTH=8).
// Expected results come from a transaction-level model that uses plain integer arithmetic.
module tb_shift_reg_universal;
    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic [2:0]    Op = '0;
    logic [W-1:0]  D = '0;
    logic [W-1:0]  K = '0;
    logic [AW-1:0] Amt = '0;
    logic          Sin = 1'b0;
    logic          Clr = 1'b0;
    logic [W-1:0]  Q, Qbar;
    logic          Sout, Busy, Done;

    int checks = 0;
    int errors = 0;
    logic [7:0] mq;
    logic       ms;
    int         exp_busy;
    bit         sin_hist[$];
    int         busy_cnt, done_cnt;

    shift_reg_universal #(.WIDTH(W), .AMT_W(AW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Op(Op), .D(D), .K(K),
        .Amt(Amt), .Sin(Sin), .Clr(Clr), .Q(Q), .Qbar(Qbar), .Sout(Sout),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issue one operation, then run it to completion (bounded). While Busy, scramble the inputs the design must ignore.
    task automatic do_op(input logic [2:0] op, input logic [7:0] d, input logic [7:0] k,
                         input int amt, input int sin_sel);
        sin_hist.delete();
        Start = 1'b1; Op = op; D = d; K = k; Amt = AW'(amt);
        Sin = (sin_sel == 2) ? 1'($urandom) : 1'(sin_sel);
        sin_hist.push_back(Sin);
        tick();
        Start = 1'b0; Op = 3'($urandom); D = 8'($urandom); K = 8'($urandom); Amt = AW'($urandom);
        busy_cnt = 0;
        done_cnt = int'(Done);
        while (Busy && busy_cnt < 40) begin
            Sin = (sin_sel == 2) ? 1'($urandom) : 1'(sin_sel);
            sin_hist.push_back(Sin);
            tick();
            busy_cnt++;
            done_cnt += int'(Done);
        end
    endtask

    // Reference: apply the whole operation at once to the model register mq / ms.
    task automatic model_op(input logic [2:0] op, input logic [7:0] d, input logic [7:0] k, input int amt);
        int n, qi, s;
        n  = (amt > W) ? W : amt;
        qi = int'(mq);
        s  = int'(ms);
        exp_busy = 0;
        case (op)
            3'd1: qi = int'(d);
            3'd6: qi = qi ^ int'(d);
            3'd7: for (int i = 0; i < W; i++) begin
                if (d[i] && k[i])  qi = qi ^ (1 << i);
                else if (d[i])     qi = qi | (1 << i);
                else if (k[i])     qi = qi & ~(1 << i);
            end
            3'd2, 3'd3, 3'd4, 3'd5: begin
                for (int i = 0; i < n; i++) begin
                    case (op)
                        3'd2: begin s = (qi >> 7) & 1; qi = ((qi << 1) | int'(sin_hist[i])) & 255; end
                        3'd3: begin s = qi & 1; qi = (qi >> 1) | (int'(sin_hist[i]) << 7); end
                        3'd4: begin s = (qi >> 7) & 1; qi = ((qi << 1) | s) & 255; end
                        default: begin s = qi & 1; qi = (qi >> 1) | (s << 7); end
                    endcase
                end
                exp_busy = (n > 1) ? n - 1 : 0;
            end
            default: ;
        endcase
        mq = 8'(qi);
        ms = 1'(s);
    endtask

    task automatic test_reset();
        checks++; if (Q !== 8'h00)   begin errors++; $display("FAIL reset_q: got %h expected 00", Q); end
        checks++; if (Qbar !== 8'hFF) begin errors++; $display("FAIL reset_qbar: got %h expected ff", Qbar); end
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Sout !== 1'b0)
            begin errors++; $display("FAIL reset_flags: busy=%b done=%b sout=%b expected 000", Busy, Done, Sout); end
        tick();
        Reset_n = 1'b1;
        do_op(3'd1, 8'hA5, 8'h00, 0, 0);
        checks++; if (Q !== 8'hA5) begin errors++; $display("FAIL reset_preload: got %h expected a5", Q); end
        Start = 1'b1; Op = 3'd2; Amt = AW'(5); Sin = 1'b1;
        tick();
        Start = 1'b0;
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL reset_busy_before: got %b expected 1", Busy); end
        #2 Reset_n = 1'b0;
        #1;
        checks++; if (Q !== 8'h00 || Qbar !== 8'hFF)
            begin errors++; $display("FAIL reset_async_q: q=%h qbar=%h expected 00/ff", Q, Qbar); end
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || Sout !== 1'b0)
            begin errors++; $display("FAIL reset_async_flags: busy=%b done=%b sout=%b expected 000", Busy, Done, Sout); end
        #1 Reset_n = 1'b1;
        tick();
        mq = 8'h00; ms = 1'b0;
    endtask

    task automatic test_load_toggle_jk();
        do_op(3'd1, 8'h3C, 8'h00, 0, 0);
        checks++; if (Q !== 8'h3C) begin errors++; $display("FAIL load_q: got %h expected 3c", Q); end
        checks++; if (done_cnt != 1 || busy_cnt != 0)
            begin errors++; $display("FAIL load_done: done=%0d busy=%0d expected 1/0", done_cnt, busy_cnt); end
        tick();
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL load_done_drop: got %b expected 0", Done); end
        do_op(3'd6, 8'h0F, 8'h00, 0, 0);
        checks++; if (Q !== 8'h33) begin errors++; $display("FAIL toggle_q: got %h expected 33", Q); end
        do_op(3'd7, 8'hF0, 8'h11, 0, 0);
        checks++; if (Q !== 8'hE2) begin errors++; $display("FAIL jk_q: got %h expected e2", Q); end
        checks++; if (Sout !== 1'b0) begin errors++; $display("FAIL jk_sout: got %b expected 0", Sout); end
        mq = 8'hE2;
    endtask

    task automatic test_shift_left();
        do_op(3'd1, 8'h81, 8'h00, 0, 0);
        do_op(3'd2, 8'h00, 8'h00, 3, 1);
        checks++; if (Q !== 8'h0F) begin errors++; $display("FAIL shl_q: got %h expected 0f", Q); end
        checks++; if (Sout !== 1'b0) begin errors++; $display("FAIL shl_sout: got %b expected 0", Sout); end
        checks++; if (busy_cnt != 2 || done_cnt != 1)
            begin errors++; $display("FAIL shl_timing: busy=%0d done=%0d expected 2/1", busy_cnt, done_cnt); end
        tick();
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL shl_done_drop: got %b expected 0", Done); end
        mq = 8'h0F; ms = 1'b0;
    endtask

    task automatic test_rotate_right();
        do_op(3'd1, 8'h01, 8'h00, 0, 0);
        do_op(3'd5, 8'h00, 8'h00, 9, 2);
        checks++; if (Q !== 8'h01 || busy_cnt != 7 || done_cnt != 1)
            begin errors++; $display("FAIL ror9: q=%h busy=%0d done=%0d expected 01/7/1", Q, busy_cnt, done_cnt); end
        do_op(3'd5, 8'h00, 8'h00, 1, 2);
        checks++; if (Q !== 8'h80 || Sout !== 1'b1 || busy_cnt != 0)
            begin errors++; $display("FAIL ror1: q=%h sout=%b busy=%0d expected 80/1/0", Q, Sout, busy_cnt); end
        do_op(3'd5, 8'h00, 8'h00, 0, 2);
        checks++; if (Q !== 8'h80 || Sout !== 1'b1 || busy_cnt != 0 || done_cnt != 1)
            begin errors++; $display("FAIL ror0: q=%h sout=%b busy=%0d done=%0d expected 80/1/0/1", Q, Sout, busy_cnt, done_cnt); end
        do_op(3'd1, 8'h01, 8'h00, 0, 0);
        checks++; if (Sout !== 1'b1) begin errors++; $display("FAIL load_keeps_sout: got %b expected 1", Sout); end
        mq = 8'h01; ms = 1'b1;
    endtask

    task automatic test_start_during_busy();
        int busy_seen;
        do_op(3'd1, 8'h3C, 8'h00, 0, 0);
        Start = 1'b1; Op = 3'd2; Amt = AW'(4); Sin = 1'b0;
        tick();
        Op = 3'd1; D = 8'hFF;
        busy_seen = int'(Busy);
        for (int i = 0; i < 3; i++) begin
            tick();
            busy_seen += int'(Busy);
        end
        Start = 1'b0;
        checks++; if (Q !== 8'hC0 || Sout !== 1'b1)
            begin errors++; $display("FAIL busy_start_q: q=%h sout=%b expected c0/1", Q, Sout); end
        checks++; if (busy_seen != 3 || Done !== 1'b1)
            begin errors++; $display("FAIL busy_start_timing: busy=%0d done=%b expected 3/1", busy_seen, Done); end
        tick();
        checks++; if (Q !== 8'hC0 || Done !== 1'b0)
            begin errors++; $display("FAIL busy_start_after: q=%h done=%b expected c0/0", Q, Done); end
        mq = 8'hC0; ms = 1'b1;
    endtask

    task automatic test_clr_abort();
        do_op(3'd1, 8'hA5, 8'h00, 0, 0);
        Start = 1'b1; Op = 3'd2; Amt = AW'(5); Sin = 1'b1;
        tick();
        Start = 1'b0;
        checks++; if (Busy !== 1'b1 || Q !== 8'h4B || Sout !== 1'b1)
            begin errors++; $display("FAIL clr_pre: busy=%b q=%h sout=%b expected 1/4b/1", Busy, Q, Sout); end
        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        checks++; if (Q !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0 || Sout !== 1'b0)
            begin errors++; $display("FAIL clr_abort: q=%h busy=%b done=%b sout=%b expected 00/0/0/0", Q, Busy, Done, Sout); end
        Start = 1'b1; Op = 3'd1; D = 8'h5A;
        tick();
        Start = 1'b0;
        checks++; if (Q !== 8'h5A || Done !== 1'b1)
            begin errors++; $display("FAIL clr_restart: q=%h done=%b expected 5a/1", Q, Done); end
        Clr = 1'b1; Start = 1'b1; Op = 3'd1; D = 8'hFF;
        tick();
        Clr = 1'b0; Start = 1'b0;
        checks++; if (Q !== 8'h00 || Done !== 1'b0)
            begin errors++; $display("FAIL clr_over_start: q=%h done=%b expected 00/0", Q, Done); end
        mq = 8'h00; ms = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_op(3'd1, 8'h0F, 8'h00, 0, 0);
        do_op(3'd2, 8'h00, 8'h00, 2, 0);
        checks++; if (Q !== 8'h3C || Done !== 1'b1)
            begin errors++; $display("FAIL b2b_shift: q=%h done=%b expected 3c/1", Q, Done); end
        do_op(3'd1, 8'h99, 8'h00, 0, 0);
        checks++; if (Q !== 8'h99 || done_cnt != 1)
            begin errors++; $display("FAIL b2b_load: q=%h done=%0d expected 99/1", Q, done_cnt); end
        mq = 8'h99; ms = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [7:0] d, k;
        int amt;
        for (int it = 0; it < 40; it++) begin
            op  = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            k   = 8'($urandom);
            amt = $urandom_range(0, 15);
            do_op(op, d, k, amt, 2);
            model_op(op, d, k, amt);
            checks++; if (Q !== mq || Qbar !== ~mq)
                begin errors++; $display("FAIL rand_q: op=%0d amt=%0d q=%h qbar=%h expected %h", op, amt, Q, Qbar, mq); end
            checks++; if (Sout !== ms)
                begin errors++; $display("FAIL rand_sout: op=%0d amt=%0d got %b expected %b", op, amt, Sout, ms); end
            checks++; if (busy_cnt != exp_busy || done_cnt != 1)
                begin errors++; $display("FAIL rand_timing: op=%0d amt=%0d busy=%0d done=%0d expected %0d/1", op, amt, busy_cnt, done_cnt, exp_busy); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_load_toggle_jk();
        test_shift_left();
        test_rotate_right();
        test_start_during_busy();
        test_clr_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised universal register: a WIDTH-bit storage element supporting parallel load, T-style toggle, JK update, and multi-bit shift/rotate executed one bit per clock. It is the multi-bit, multi-mode successor to the course's single-bit gated D latch and edge-triggered flip-flop. It is used wherever a lab datapath needs a loadable/shiftable register with a completion handshake. All state is edge-triggered on Clk; there are no transparent latches.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AMT_W, $clog2(WIDTH)+1, width of shift-amount input
- Clk  input  1  clock, all state updates on rising edge
- Reset_n  input  1  asynchronous active-low reset
- Start  input  1  operation request, accepted only when Busy=0
- Op  input  3  operation code, sampled on the accept edge
- D  input  WIDTH  load data / toggle mask / J vector
- K  input  WIDTH  K vector for JK op
- Amt  input  AMT_W  shift/rotate count, sampled on the accept edge
- Sin  input  1  serial input bit, sampled on every shift edge
- Clr  input  1  synchronous clear, highest synchronous priority
- Q  output  WIDTH  register contents
- Qbar  output  WIDTH  ~Q (combinational from Q)
- Sout  output  1  bit shifted/rotated out on the most recent shift edge
- Busy  output  1  multi-cycle shift in progress
- Done  output  1  one-cycle completion pulse

## Operation
- Reset (Reset_n=0, async): Q=0, Qbar=all ones, Sout=0, Busy=0, Done=0, internal count=0, FSM=IDLE.
- FSM states: IDLE, SHIFT.
- Op codes: 000 hold; 001 load (Q<=D); 010 shift left (Sin into bit 0, Sout<=Q[WIDTH-1]); 011 shift right (Sin into MSB, Sout<=Q[0]); 100 rotate left; 101 rotate right (Sout = bit moved across the end); 110 toggle (Q<=Q^D); 111 JK per bit (J=D,K=K: 00 hold, 10 set, 01 clear, 11 toggle).
- Accept: Start=1 and Busy=0 at a rising edge.
- Ops 000/001/110/111: Q updated on the accept edge; Done=1 for the following cycle; Busy stays 0.
- Shift/rotate ops: effective count n = min(Amt, WIDTH).
  - n=0: no change; Done pulses.
  - n≥1: first bit moved on the accept edge. If n=1, Done pulses and the FSM stays in IDLE. Otherwise FSM→SHIFT, Busy=1, remaining=n-1; one bit per edge; on the edge performing the last move, FSM→IDLE, Busy→0, Done→1.
- Op and direction are latched at accept. Op, Amt, D, and K changes during SHIFT are ignored. Sin is live every shift edge.
- Start while Busy=1: ignored, not queued.
- Clr=1 at an edge: Q=0, Sout=0, Busy=0, Done=0, FSM=IDLE. Clr overrides a simultaneous Start and aborts a shift in progress.
- Sout holds its value when no shift/rotate edge occurs (loads do not alter it).
- Done is low in all cycles other than the single completion cycle.

## Timing
- Single-cycle ops: Q valid 1 edge after accept; Done high during cycle after accept edge.
- Shift of n≥1: Q final after n edges (accept edge inclusive); Busy high for n-1 cycles; Done high in cycle after final edge.
- Back-to-back: new Start accepted on the same edge Done is asserted (Busy already 0).
- Reset assertion mid-shift: immediate, async return to reset values. Deassertion is synchronised externally.

## Test plan
- Reset: Reset_n=0 mid-shift (WIDTH=8, Q=8'hA5, Busy=1) -> Q=0, Qbar=8'hFF, Busy=0, Done=0 immediately, without waiting for a clock edge.
- Load/toggle/JK: load D=8'h3C -> Q=8'h3C, Done pulse 1 cycle. Toggle D=8'h0F -> Q=8'h33. JK D=8'hF0, K=8'h11 -> Q=8'hE2 (bits 7:5 set, bit 4 toggled, bit 0 cleared, rest held).
- Shift left: Q=8'h81, Amt=3, Sin=1 -> Busy high 2 cycles, Q=8'h0F after 3 edges, Sout=0, Done pulse after edge 3.
- Rotate right: Q=8'h01, Amt=9 (clamped to 8) -> 8 edges, Q=8'h01 at the end. Separately, Amt=0 -> Q unchanged with an immediate Done.
- Start during Busy with Op=001, D=8'hFF -> ignored, shift completes unaffected.
- Clr on the 2nd edge of a 5-bit shift -> Q=0, Busy=0, no Done. A subsequent Start is accepted on the next edge.
